// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared JTAG definitions: TAP state encodings (the 1149.1 table values),
// instruction opcodes and the fixed pattern loaded into the IR shift stage
// during Capture-IR.
// ---------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    // Opcodes; BYPASS is all ones at whatever IR width is in use, and any
    // opcode not listed here also decodes as BYPASS.
    localparam int unsigned OP_EXTEST         = 0;
    localparam int unsigned OP_IDCODE         = 1;
    localparam int unsigned OP_SAMPLE_PRELOAD = 2;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// ---------------------------------------------------------------------------
// tap_fsm
// IEEE 1149.1 TAP state machine, next-state logic and state register only.
//
// Ports:
//   tck        in   test clock, state advances on rising edge
//   trst       in   synchronous active-high reset to TLR
//   tms        in   test mode select, picks the next state
//   state      out  current TAP state
//   state_next out  state that will be entered on the next rising edge
//
// state  | meaning
// -------+---------------------------------------------
// TLR    | test-logic-reset, IR forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | choose DR column (tms=1 moves on to IR)
// CAP_DR | parallel load of selected data register
// SH_DR  | shift selected data register
// EX1_DR | leave shift; go to update or pause
// PA_DR  | pause, all registers hold
// EX2_DR | leave pause; resume shift or update
// UPD_DR | commit shifted data
// SEL_IR | choose IR column (tms=1 returns to TLR)
// CAP_IR | load capture pattern into IR shift stage
// SH_IR  | shift IR
// EX1_IR | leave shift; go to update or pause
// PA_IR  | pause, all registers hold
// EX2_IR | leave pause; resume shift or update
// UPD_IR | commit new instruction
// ---------------------------------------------------------------------------
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state,
    output tap_state_t state_next
);

    always_comb begin
        state_next = TLR;
        case (state)
            TLR:    state_next = tms ? TLR    : RTI;
            RTI:    state_next = tms ? SEL_DR : RTI;
            SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tms ? EX1_DR : SH_DR;
            SH_DR:  state_next = tms ? EX1_DR : SH_DR;
            EX1_DR: state_next = tms ? UPD_DR : PA_DR;
            PA_DR:  state_next = tms ? EX2_DR : PA_DR;
            EX2_DR: state_next = tms ? UPD_DR : SH_DR;
            UPD_DR: state_next = tms ? SEL_DR : RTI;
            SEL_IR: state_next = tms ? TLR    : CAP_IR;
            CAP_IR: state_next = tms ? EX1_IR : SH_IR;
            SH_IR:  state_next = tms ? EX1_IR : SH_IR;
            EX1_IR: state_next = tms ? UPD_IR : PA_IR;
            PA_IR:  state_next = tms ? EX2_IR : PA_IR;
            EX2_IR: state_next = tms ? UPD_IR : SH_IR;
            UPD_IR: state_next = tms ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
// JTAG TAP controller: TAP state machine, instruction register, BYPASS and
// IDCODE data registers, TDO multiplexer and the boundary-scan chain
// sequencing enables. Single clock domain (tck); the BSR cells are driven
// with enables rather than gated clocks.
//
// Ports:
//   tck         in   test clock
//   trst        in   synchronous active-high reset
//   tms         in   test mode select
//   tdi         in   serial test data in
//   tdo         out  registered serial test data out
//   bsr_tdi     out  serial data into BSR chain (tdi passthrough)
//   bsr_tdo     in   serial data returned from BSR chain end
//   bsr_capture out  BSR cells load parallel input this cycle
//   bsr_shift   out  BSR cells shift one position this cycle
//   bsr_update  out  BSR cells copy shift stage to update latch this cycle
//   bsr_mode    out  1 = BSR update latch drives the pins (EXTEST)
//   tap_state   out  current TAP state encoding
// ---------------------------------------------------------------------------
module tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       bsr_tdi,
    input  logic       bsr_tdo,
    output logic       bsr_capture,
    output logic       bsr_shift,
    output logic       bsr_update,
    output logic       bsr_mode,
    output logic [3:0] tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] IR_CAP_PAT = IR_WIDTH'(IR_CAPTURE);

    tap_state_t          state;
    tap_state_t          state_next;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         idreg;
    logic                bypass_reg;
    logic                sel_bsr;
    logic                sel_id;

    tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .state      (state),
        .state_next (state_next)
    );

    assign tap_state = state;
    assign bsr_tdi   = tdi;

    // Anything that is not EXTEST, SAMPLE/PRELOAD or IDCODE falls through
    // to the 1-bit bypass register.
    assign sel_bsr = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
    assign sel_id  = (ir == IR_IDCODE);

    assign bsr_capture = sel_bsr && (state == CAP_DR);
    assign bsr_shift   = sel_bsr && (state == SH_DR);
    assign bsr_update  = sel_bsr && (state == UPD_DR);

    always_ff @(posedge tck) begin
        if (trst) begin
            ir         <= IR_IDCODE;
            ir_shift   <= '0;
            idreg      <= IDCODE_VAL;
            bypass_reg <= 1'b0;
            tdo        <= 1'b0;
            bsr_mode   <= 1'b0;
        end else begin
            case (state)
                CAP_IR: ir_shift <= IR_CAP_PAT;
                SH_IR: begin
                    tdo      <= ir_shift[0];
                    ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                end
                UPD_IR: begin
                    ir       <= ir_shift;
                    bsr_mode <= (ir_shift == IR_EXTEST);
                end
                CAP_DR: begin
                    idreg      <= IDCODE_VAL;
                    bypass_reg <= 1'b0;
                end
                SH_DR: begin
                    if (sel_bsr) begin
                        tdo <= bsr_tdo;
                    end else if (sel_id) begin
                        tdo   <= idreg[0];
                        idreg <= {tdi, idreg[31:1]};
                    end else begin
                        tdo        <= bypass_reg;
                        bypass_reg <= tdi;
                    end
                end
                default: ;
            endcase

            // Entering TLR through tms acts like a soft reset of the
            // instruction; UPD_IR can never lead directly into TLR, so this
            // never fights the IR update above.
            if (state_next == TLR) begin
                ir       <= IR_IDCODE;
                bsr_mode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_tap_controller
// Directed bench for tap_controller. A behavioural model of the TAP (state
// graph as a lookup table, registers as plain integers) is checked against
// the DUT on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_tap_controller;

    localparam int          IRW = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;

    localparam logic [3:0] S_SDR = 4'h2, S_PDR = 4'h3, S_UDR = 4'h5,
                           S_CDR = 4'h6, S_SIR = 4'hA, S_UIR = 4'hD,
                           S_CIR = 4'hE, S_TLR = 4'hF;

    // Standard 1149.1 graph indexed by encoding: next state for tms=0 / tms=1.
    logic [3:0] nx0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nx1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo, bsr_tdi, bsr_tdo, bsr_capture, bsr_shift, bsr_update, bsr_mode;
    logic [3:0] tap_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tck = ~tck;

    tap_controller #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV)) dut (
        .tck         (tck),
        .trst        (trst),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .bsr_tdi     (bsr_tdi),
        .bsr_tdo     (bsr_tdo),
        .bsr_capture (bsr_capture),
        .bsr_shift   (bsr_shift),
        .bsr_update  (bsr_update),
        .bsr_mode    (bsr_mode),
        .tap_state   (tap_state)
    );

    // Stand-in boundary-scan chain so bsr_tdo carries real data.
    logic [5:0] chain = 6'b101100;
    assign bsr_tdo = chain[0];
    always @(posedge tck) if (bsr_shift) chain <= {bsr_tdi, chain[5:1]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input logic [IRW-1:0] v);
        if (v == 0 || v == 2) return 0;   // boundary-scan register
        if (v == 1) return 1;             // idcode
        return 2;                         // bypass
    endfunction

    // ---------------- behavioural model ----------------
    logic [3:0]     m_st = S_TLR;
    logic [IRW-1:0] m_ir = 1, m_irs = 0;
    logic [31:0]    m_id = IDV;
    logic           m_byp = 0, m_tdo = 0, m_mode = 0;
    bit             m_valid = 0;

    always @(posedge tck) begin : model
        logic [3:0] nst;
        if (trst) begin
            m_st = S_TLR; m_ir = 1; m_irs = 0; m_byp = 0; m_tdo = 0; m_mode = 0;
            m_valid = 1;
        end else if (m_valid) begin
            nst = tms ? nx1[m_st] : nx0[m_st];
            if (m_st == S_CIR) m_irs = 1;
            else if (m_st == S_SIR) begin
                m_tdo = m_irs[0];
                m_irs = (m_irs >> 1) | (IRW'(tdi) << (IRW - 1));
            end else if (m_st == S_UIR) begin
                m_ir   = m_irs;
                m_mode = (m_irs == 0);
            end else if (m_st == S_CDR) begin
                m_id  = IDV;
                m_byp = 0;
            end else if (m_st == S_SDR) begin
                case (sel_of(m_ir))
                    0: m_tdo = bsr_tdo;
                    1: begin
                        m_tdo = m_id[0];
                        m_id  = (m_id >> 1) | (32'(tdi) << 31);
                    end
                    default: begin
                        m_tdo = m_byp;
                        m_byp = tdi;
                    end
                endcase
            end
            if (nst == S_TLR) begin
                m_ir   = 1;
                m_mode = 0;
            end
            m_st = nst;
        end
    end

    always @(negedge tck) begin
        if (m_valid) begin
            check("tap_state",   tap_state,   m_st);
            check("tdo",         tdo,         m_tdo);
            check("bsr_capture", bsr_capture, (m_st == S_CDR) && sel_of(m_ir) == 0);
            check("bsr_shift",   bsr_shift,   (m_st == S_SDR) && sel_of(m_ir) == 0);
            check("bsr_update",  bsr_update,  (m_st == S_UDR) && sel_of(m_ir) == 0);
            check("bsr_mode",    bsr_mode,    m_mode);
            check("bsr_tdi",     bsr_tdi,     tdi);
        end
    end

    // ---------------- activity counters ----------------
    int cyc = 0;
    int n_cap, n_sh, n_upd, n_sh_pause, n_pause;
    int first_cap, first_sh, last_sh, first_upd;

    always @(posedge tck) begin
        cyc++;
        if (bsr_capture) begin n_cap++; if (first_cap < 0) first_cap = cyc; end
        if (bsr_shift) begin
            n_sh++;
            if (first_sh < 0) first_sh = cyc;
            last_sh = cyc;
            if (tap_state == S_PDR) n_sh_pause++;
        end
        if (bsr_update) begin n_upd++; if (first_upd < 0) first_upd = cyc; end
        if (tap_state == S_PDR) n_pause++;
    end

    task automatic clear_counts();
        n_cap = 0; n_sh = 0; n_upd = 0; n_sh_pause = 0; n_pause = 0;
        first_cap = -1; first_sh = -1; last_sh = -1; first_upd = -1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // From RTI: shift val into IR (LSB first), update, return to RTI.
    task automatic ir_scan(input logic [3:0] val, output logic [3:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, val[i]);
            cap[i] = tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: capture, n shifts of pat (LSB first), update, return to RTI.
    task automatic dr_scan(input int n, input logic [7:0] pat, output logic [7:0] out);
        out = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, pat[i]);
            out[i] = tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [3:0]  cap;
        logic [7:0]  out;
        clear_counts();

        // Reset
        trst = 1'b1;
        step(0, 0);
        trst = 1'b0;
        check("rst_state", tap_state, S_TLR);
        check("rst_tdo", tdo, 0);
        check("rst_mode", bsr_mode, 0);

        // IDCODE read straight after reset
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        got = '0;
        for (int k = 0; k < 32; k++) begin
            step(0, 0);
            got[k] = tdo;
        end
        check("idcode_read", got, IDV);
        step(1, 0); step(1, 0); step(0, 0);

        // BYPASS via explicit opcode
        ir_scan(4'hF, cap);
        check("ir_capture", cap, 4'b0001);
        dr_scan(6, 8'b0000_1101, out);
        check("bypass_delay", out[5:0], 6'b011010);

        // EXTEST sequencing
        ir_scan(4'h0, cap);
        check("extest_mode", bsr_mode, 1);
        clear_counts();
        dr_scan(5, 8'b0001_0011, out);
        check("extest_cap_cnt", n_cap, 1);
        check("extest_sh_cnt", n_sh, 5);
        check("extest_upd_cnt", n_upd, 1);
        check("extest_order_cap", first_cap < first_sh, 1);
        check("extest_order_upd", last_sh < first_upd, 1);

        // Pause in the middle of an EXTEST scan
        clear_counts();
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(1, 0);
        step(0, 0);
        step(0, 0); step(0, 0); step(1, 0);
        step(0, 0);
        step(0, 1); step(0, 0); step(1, 1);
        step(1, 0); step(0, 0);
        check("pause_cycles", n_pause, 3);
        check("pause_sh_cnt", n_sh, 5);
        check("pause_sh_during", n_sh_pause, 0);
        check("pause_cap_cnt", n_cap, 1);
        check("pause_upd_cnt", n_upd, 1);

        // Undefined opcode behaves as BYPASS
        ir_scan(4'b0111, cap);
        check("undef_mode", bsr_mode, 0);
        clear_counts();
        dr_scan(4, 8'b0000_0011, out);
        check("undef_bypass", out[3:0], 4'b0110);
        check("undef_no_bsr", n_cap + n_sh + n_upd, 0);

        // tms=1 for five edges from SH_IR reaches TLR
        ir_scan(4'h0, cap);
        check("extest_mode2", bsr_mode, 1);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check("in_sh_ir", tap_state, S_SIR);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            if (i < 4) check("tms_rst_early", tap_state == S_TLR, 0);
        end
        check("tms_rst_state", tap_state, S_TLR);
        check("tms_rst_mode", bsr_mode, 0);
        step(0, 0);
        dr_scan(2, 8'h00, out);
        check("tms_rst_idcode", out[1:0], 2'b01);

        // Reset in the middle of an EXTEST DR scan
        ir_scan(4'h0, cap);
        clear_counts();
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 0);
        trst = 1'b1;
        step(0, 0);
        trst = 1'b0;
        check("midrst_state", tap_state, S_TLR);
        check("midrst_mode", bsr_mode, 0);
        check("midrst_tdo", tdo, 0);
        step(1, 0); step(1, 0); step(1, 0);
        check("midrst_no_upd", n_upd, 0);
        check("midrst_cap_cnt", n_cap, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
